// File: rtl/data_mem_mmio_pkg.sv
// Shared CPU package: MMIO address map, timer control bit positions and the
// address decoder used by the data memory.
package data_mem_mmio_pkg;

    localparam int RAM_WORDS_DEFAULT = 256;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGITS,
        SEL_SYSTICK
    } sel_e;

    // Byte-lane bits are ignored everywhere, so decode on the word address.
    function automatic sel_e decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        if (word < ram_bytes) return SEL_RAM;
        case (word)
            ADDR_TH:      return SEL_TH;
            ADDR_TL:      return SEL_TL;
            ADDR_TCON:    return SEL_TCON;
            ADDR_LED:     return SEL_LED;
            ADDR_DIGITS:  return SEL_DIGITS;
            ADDR_SYSTICK: return SEL_SYSTICK;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_mmio_timer.sv
// Reloading timer: TH reload value, TL up-counter, TCON control/status and a
// registered interrupt request.
module mmio_timer
    import data_mem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_th,
    input  logic        we_tl,
    input  logic        we_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic        overflow;
    logic [31:0] tl_next;
    logic [2:0]  tcon_next;

    // A CPU write to TL pre-empts the overflow event entirely: no reload, no status set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        overflow  = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF) && !we_tl;
        tl_next   = tl;
        tcon_next = tcon;
        if (we_tl)
            tl_next = wdata;
        else if (overflow)
            tl_next = th;
        else if (tcon[TCON_EN])
            tl_next = tl + 32'd1;
        if (we_tcon)
            tcon_next = wdata[2:0];
        else if (overflow && tcon[TCON_IE])
            tcon_next[TCON_IS] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            if (we_th) th <= wdata;
            tl   <= tl_next;
            tcon <= tcon_next;
            irq  <= tcon[TCON_IS] & tcon[TCON_IE];
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory with memory-mapped peripherals: word RAM, timer, LED and
// seven-segment registers and a free-running SYSTICK counter.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    sel_e          sel;
    logic [7:0]    led_q;
    logic [11:0]   digits_q;
    logic [31:0]   systick;
    logic [31:0]   th, tl;
    logic [2:0]    tcon;

    assign sel     = decode_addr(Address, RAM_BYTES);
    assign ram_idx = Address[AW+1:2];
    assign leds    = led_q;
    assign digits  = digits_q;

    // NOTE: RAM has no reset so it maps onto plain memory; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && sel == SEL_RAM)
            ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= '0;
            digits_q <= '0;
            systick  <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (MemWrite && sel == SEL_LED)    led_q    <= WriteData[7:0];
            if (MemWrite && sel == SEL_DIGITS) digits_q <= WriteData[11:0];
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_th   (MemWrite && sel == SEL_TH),
        .we_tl   (MemWrite && sel == SEL_TL),
        .we_tcon (MemWrite && sel == SEL_TCON),
        .wdata   (WriteData),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            case (sel)
                SEL_RAM:     ReadData = ram[ram_idx];
                SEL_TH:      ReadData = th;
                SEL_TL:      ReadData = tl;
                SEL_TCON:    ReadData = {29'd0, tcon};
                SEL_LED:     ReadData = {24'd0, led_q};
                SEL_DIGITS:  ReadData = {20'd0, digits_q};
                SEL_SYSTICK: ReadData = systick;
                default:     ReadData = '0;
            endcase
        end
    end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MemRead  input  1  load enable from MEM stage.
REQ-005 SHALL have port MemWrite  input  1  store enable from MEM stage.
REQ-006 SHALL have port Address  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port WriteData  input  32  store data.
REQ-008 SHALL have port ReadData  output  32  load data, feeds MEM_MemReadData of the MEM/WB register.
REQ-009 SHALL have port leds  output  8  LED register.
REQ-010 SHALL have port digits  output  12  seven-segment register: [11:8] anode select, [7:0] segments.
REQ-011 SHALL have port irq  output  1  timer interrupt request.

Function
REQ-012 SHALL decode the address map as follows:
- 0x00000000 .. 4*RAM_WORDS-1: RAM, index Address[log2(RAM_WORDS)+1:2].
- 0x40000000: TH.
- 0x40000004: TL.
- 0x40000008: TCON[2:0].
- 0x4000000C: LED[7:0].
- 0x40000010: DIGITS[11:0].
- 0x40000014: SYSTICK (read-only).
REQ-013 SHALL make ReadData combinational: decoded value when MemRead=1, else 32'h0; narrow registers zero-extended.
REQ-014 SHALL return 32'h0 for reads of unmapped addresses and ignore writes to them.
REQ-015 SHALL commit writes at posedge clk when MemWrite=1; a same-cycle read returns the pre-write value.
REQ-016 SHALL write LED and DIGITS from WriteData[7:0] and WriteData[11:0] respectively; leds/digits outputs driven directly from those registers.
REQ-017 SHALL ignore writes to SYSTICK.
REQ-018 SHALL increment SYSTICK by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
REQ-019 SHALL define TCON bits: [0] enable, [1] interrupt enable, [2] interrupt status.
REQ-020 SHALL, when TCON[0]=1, per cycle: TL==32'hFFFFFFFF -> TL<=TH, and TCON[2]<=1 if TCON[1]=1; otherwise TL<=TL+1.
REQ-021 SHALL hold TL when TCON[0]=0.
REQ-022 SHALL give a CPU write priority over the hardware update of the same register in the same cycle (TL write beats count/reload; TCON write beats status set).
REQ-023 SHALL clear interrupt status only by a CPU write with WriteData[2]=0.
REQ-024 SHALL drive irq = TCON[2] & TCON[1], registered, with no combinational path from inputs.
REQ-025 SHALL have zero-cycle read latency and one-cycle write latency; a register written at edge N is readable from cycle N+1.

Reset
REQ-026 SHALL asynchronously clear TH, TL, TCON, LED, DIGITS and SYSTICK to 0 while reset=1 (leds=0, digits=0, irq=0).
REQ-027 SHALL not reset RAM contents; RAM writes are suppressed while reset=1.
REQ-028 SHALL resume counting on the first posedge after reset deasserts, with SYSTICK=1 after that edge.

Structure
REQ-029 SHALL place the MMIO address constants, TCON bit indices and the default RAM_WORDS in the shared CPU package.
REQ-030 SHALL implement TH/TL/TCON and irq in one sub-module, mmio_timer; RAM, SYSTICK, LED/DIGITS and the read mux stay in data_mem_mmio.

Verification
REQ-031 SHALL cover RAM: write 0xDEADBEEF to 0x00000010, read 0x00000010 next cycle -> 0xDEADBEEF; read 0x00000013 -> same word.
REQ-032 SHALL cover timer reload: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3b011. Required sequence after 1 cycle: TL=0xFFFFFFFF. After 2 cycles: TL=0xFFFFFFFD, irq=1 one cycle later.
REQ-033 SHALL cover interrupt clear: with irq=1, write TCON=3b011 -> irq=0 next cycle, counting continues.
REQ-034 SHALL cover write priority: write TL=0x00000005 in the overflow cycle -> TL=0x00000005, no reload, TCON[2] unchanged.
REQ-035 SHALL cover SYSTICK/MMIO: read 0x40000014 at two cycles 10 apart -> difference 10; write 0x40000014 ignored; write LED=0xA5 -> leds=0xA5; read 0x50000000 -> 0.
REQ-036 SHALL cover reset mid-operation: assert reset while timer is running with irq=1 -> TL, TCON, LED, SYSTICK=0 and irq=0 immediately; a RAM word written before reset still reads back its value.
